// File: rtl/udma_ts_pkg.sv
// rtl/udma_ts_pkg.sv - shared types and word packing for the timestamp capture front-end
//
// Purpose: constants, edge mode enum and the RX word packing helper used by
//          udma_ts_mc_capture.
// Contents:
//   DATASIZE_32  uDMA datasize code for 32-bit words
//   edge_mode_e  per-channel strobe event mode
//   pack_word()  places timestamp data at bit 0 and channel ID at chid_lsb

package udma_ts_pkg;

  localparam logic [1:0] DATASIZE_32 = 2'b10;

  typedef enum logic {
    EDGE_TOGGLE = 1'b0,
    EDGE_RISE   = 1'b1
  } edge_mode_e;

  // Data is masked to data_w bits and the channel ID to chid_w bits, so any
  // bits outside those two fields are guaranteed zero.
  function automatic logic [31:0] pack_word(
    input logic [31:0] data,
    input logic [31:0] chid,
    input int          data_w,
    input int          chid_lsb,
    input int          chid_w
  );
    logic [31:0] dmask;
    logic [31:0] cmask;
    dmask = (data_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << data_w) - 32'd1);
    cmask = (chid_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << chid_w) - 32'd1);
    return (data & dmask) | ((chid & cmask) << chid_lsb);
  endfunction

endpackage

// File: rtl/udma_ts_fifo.sv
// rtl/udma_ts_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: buffers packed timestamp words between the capture arbiter and the
//          uDMA RX stream. The head entry is visible on data_o while not empty.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   push_i/data_i write request and word; ignored when full unless a pop is taken
//   pop_i         read request; ignored when empty
//   data_o        head word (zero when empty)
//   full_o/empty_o/level_o  occupancy status

module udma_ts_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  // A full FIFO still accepts a write when the head is leaving this cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/udma_ts_mc_capture.sv
// rtl/udma_ts_mc_capture.sv - multi-channel timestamp capture into the uDMA RX stream
//
// Purpose: synchronises NB_CH asynchronous TimeSync strobes, captures each
//          channel's timestamp on an event, arbitrates captures round-robin into
//          a FWFT FIFO and drains it as 32-bit words. Tracks dropped captures
//          and raises threshold-based pending events.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cfg_ch_en_i                  per-channel capture enable
//   cfg_edge_mode_i              per-channel mode: 0 toggle, 1 rising edge only
//   cfg_evt_thr_i                transfers per pending event (0 behaves as 1)
//   cfg_pending_clr_i            clears the transfer counter
//   cfg_ovf_clr_i                clears ovf_o and drop_cnt_o
//   ts_valid_async_i, ts_data_i  asynchronous strobes and per-channel timestamps
//   data_rx_o/_valid_o/_ready_i  RX word stream
//   data_rx_datasize_o           fixed 32-bit datasize code
//   pending_event_o              one-cycle pulse after the threshold transfer
//   pending_cnt_o                transfers since last event or clear
//   fifo_level_o                 FIFO occupancy
//   ovf_o, drop_cnt_o            sticky drop flag, saturating drop counter

module udma_ts_mc_capture
  import udma_ts_pkg::*;
#(
  parameter int NB_CH         = 4,
  parameter int TS_DATA_WIDTH = 28,
  parameter int TS_CHID_LSB   = 28,
  parameter int TS_CHID_WIDTH = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int TRANS_SIZE    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NB_CH-1:0]              cfg_ch_en_i,
  input  logic [NB_CH-1:0]              cfg_edge_mode_i,
  input  logic [TRANS_SIZE-3:0]         cfg_evt_thr_i,
  input  logic                          cfg_pending_clr_i,
  input  logic                          cfg_ovf_clr_i,
  input  logic [NB_CH-1:0]              ts_valid_async_i,
  input  logic [NB_CH*TS_DATA_WIDTH-1:0] ts_data_i,
  output logic [31:0]                   data_rx_o,
  output logic                          data_rx_valid_o,
  input  logic                          data_rx_ready_i,
  output logic [1:0]                    data_rx_datasize_o,
  output logic                          pending_event_o,
  output logic [TRANS_SIZE-3:0]         pending_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          ovf_o,
  output logic [7:0]                    drop_cnt_o
);

  localparam int CW = TRANS_SIZE - 2;
  localparam int IW = (NB_CH > 1) ? $clog2(NB_CH) : 1;

  logic [2:0]               sync_q     [NB_CH];
  logic [TS_DATA_WIDTH-1:0] cap_data_q [NB_CH];
  logic [NB_CH-1:0]         evt_raw;
  logic [NB_CH-1:0]         evt_q;
  logic [NB_CH-1:0]         cap_vld_q;
  logic [NB_CH-1:0]         cap_pop;
  logic [NB_CH-1:0]         cap_drop;
  logic [IW-1:0]            rr_ptr_q;
  logic [IW-1:0]            grant_idx;
  logic [IW-1:0]            rr_cand;
  int                       rr_idx;
  logic                     grant_vld;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [31:0]              push_word;
  logic [4:0]               drop_n;
  logic [7:0]               drop_base;
  logic [8:0]               drop_sum;
  logic [CW-1:0]            thr_eff;
  logic [CW:0]              cnt_inc;

  assign data_rx_datasize_o = DATASIZE_32;

  // Synchronisers run regardless of enable so that re-enabling a channel with
  // a static strobe sees no stale edge. The event is registered once more so
  // the capture lands three edges after the strobe is first sampled.
  always_comb begin
    evt_raw = '0;
    for (int c = 0; c < NB_CH; c++) begin
      if (edge_mode_e'(cfg_edge_mode_i[c]) == EDGE_RISE) begin
        evt_raw[c] = sync_q[c][1] & ~sync_q[c][2];
      end else begin
        evt_raw[c] = sync_q[c][1] ^ sync_q[c][2];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NB_CH; c++) begin
        sync_q[c] <= '0;
      end
      evt_q <= '0;
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        sync_q[c] <= {sync_q[c][1:0], ts_valid_async_i[c]};
      end
      evt_q <= evt_raw;
    end
  end

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    rr_cand   = '0;
    for (int i = 0; i < NB_CH; i++) begin
      rr_idx = int'(rr_ptr_q) + i;
      if (rr_idx >= NB_CH) begin
        rr_idx = rr_idx - NB_CH;
      end
      rr_cand = IW'(rr_idx);
      if (!grant_vld && cap_vld_q[rr_cand]) begin
        grant_vld = 1'b1;
        grant_idx = rr_cand;
      end
    end
  end

  assign fifo_pop  = data_rx_valid_o & data_rx_ready_i;
  assign fifo_push = grant_vld & (~fifo_full | fifo_pop);
  assign push_word = pack_word(32'(cap_data_q[grant_idx]), 32'(grant_idx),
                               TS_DATA_WIDTH, TS_CHID_LSB, TS_CHID_WIDTH);

  // A channel being pushed this cycle frees its register, so a coincident
  // event re-captures instead of dropping.
  always_comb begin
    cap_pop  = '0;
    cap_drop = '0;
    for (int c = 0; c < NB_CH; c++) begin
      cap_pop[c]  = fifo_push && (grant_idx == IW'(c));
      cap_drop[c] = evt_q[c] & cfg_ch_en_i[c] & cap_vld_q[c] & ~cap_pop[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_vld_q <= '0;
      for (int c = 0; c < NB_CH; c++) begin
        cap_data_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        if (evt_q[c] && cfg_ch_en_i[c] && (!cap_vld_q[c] || cap_pop[c])) begin
          cap_vld_q[c]  <= 1'b1;
          cap_data_q[c] <= ts_data_i[c*TS_DATA_WIDTH +: TS_DATA_WIDTH];
        end else if (cap_pop[c]) begin
          cap_vld_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (fifo_push) begin
      rr_ptr_q <= (int'(grant_idx) == NB_CH - 1) ? '0 : grant_idx + IW'(1);
    end
  end

  udma_ts_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (push_word),
    .pop_i   (fifo_pop),
    .data_o  (data_rx_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign data_rx_valid_o = ~fifo_empty;

  // Several channels can drop in the same cycle; each one counts.
  always_comb begin
    drop_n = '0;
    for (int c = 0; c < NB_CH; c++) begin
      drop_n = drop_n + 5'(cap_drop[c]);
    end
    drop_base = cfg_ovf_clr_i ? 8'd0 : drop_cnt_o;
    drop_sum  = {1'b0, drop_base} + 9'(drop_n);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (|cap_drop) begin
        ovf_o <= 1'b1;
      end else if (cfg_ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
      drop_cnt_o <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign thr_eff = (cfg_evt_thr_i == '0) ? CW'(1) : cfg_evt_thr_i;
  assign cnt_inc = {1'b0, pending_cnt_o} + (CW+1)'(1);

  // A clear that coincides with a transfer counts that transfer as the first
  // one after the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_cnt_o   <= '0;
      pending_event_o <= 1'b0;
    end else begin
      pending_event_o <= 1'b0;
      if (fifo_pop) begin
        if (cfg_pending_clr_i) begin
          pending_cnt_o   <= CW'(1);
          pending_event_o <= (thr_eff == CW'(1));
        end else if (cnt_inc >= {1'b0, thr_eff}) begin
          pending_cnt_o   <= '0;
          pending_event_o <= 1'b1;
        end else begin
          pending_cnt_o <= cnt_inc[CW-1:0];
        end
      end else if (cfg_pending_clr_i) begin
        pending_cnt_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_udma_ts_mc_capture.sv
// tb/tb_udma_ts_mc_capture.sv - directed self-checking bench for udma_ts_mc_capture

module tb_udma_ts_mc_capture;

  localparam int NB_CH = 4;
  localparam int DW    = 28;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [NB_CH-1:0]   cfg_ch_en_i;
  logic [NB_CH-1:0]   cfg_edge_mode_i;
  logic [13:0]        cfg_evt_thr_i;
  logic               cfg_pending_clr_i;
  logic               cfg_ovf_clr_i;
  logic [NB_CH-1:0]   ts_valid_async_i;
  logic [NB_CH*DW-1:0] ts_data_i;
  logic [31:0]        data_rx_o;
  logic               data_rx_valid_o;
  logic               data_rx_ready_i;
  logic [1:0]         data_rx_datasize_o;
  logic               pending_event_o;
  logic [13:0]        pending_cnt_o;
  logic [3:0]         fifo_level_o;
  logic               ovf_o;
  logic [7:0]         drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] got [$];

  always #5 clk_i = ~clk_i;

  udma_ts_mc_capture #(
    .NB_CH(4), .TS_DATA_WIDTH(28), .TS_CHID_LSB(28), .TS_CHID_WIDTH(4),
    .FIFO_DEPTH(8), .TRANS_SIZE(16)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cfg_ch_en_i        (cfg_ch_en_i),
    .cfg_edge_mode_i    (cfg_edge_mode_i),
    .cfg_evt_thr_i      (cfg_evt_thr_i),
    .cfg_pending_clr_i  (cfg_pending_clr_i),
    .cfg_ovf_clr_i      (cfg_ovf_clr_i),
    .ts_valid_async_i   (ts_valid_async_i),
    .ts_data_i          (ts_data_i),
    .data_rx_o          (data_rx_o),
    .data_rx_valid_o    (data_rx_valid_o),
    .data_rx_ready_i    (data_rx_ready_i),
    .data_rx_datasize_o (data_rx_datasize_o),
    .pending_event_o    (pending_event_o),
    .pending_cnt_o      (pending_cnt_o),
    .fifo_level_o       (fifo_level_o),
    .ovf_o              (ovf_o),
    .drop_cnt_o         (drop_cnt_o)
  );

  task automatic do_reset();
    ts_valid_async_i  = '0;
    ts_data_i         = '0;
    data_rx_ready_i   = 1'b0;
    cfg_pending_clr_i = 1'b0;
    cfg_ovf_clr_i     = 1'b0;
    cfg_ch_en_i       = '1;
    cfg_edge_mode_i   = '0;
    cfg_evt_thr_i     = 14'd10;
    rst_i             = 1'b1;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    got.delete();
  endtask

  task automatic set_ch(input int c, input logic [27:0] d);
    ts_data_i[c*DW +: DW] = d;
    ts_valid_async_i[c]   = ~ts_valid_async_i[c];
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      if (data_rx_valid_o && data_rx_ready_i) got.push_back(data_rx_o);
      @(negedge clk_i);
    end
  endtask

  task automatic wait_xfer(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (data_rx_valid_o && data_rx_ready_i) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (data_rx_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %0b exp 0", data_rx_valid_o); end
    n_checks++; if (data_rx_o !== 32'h0) begin n_errors++; $display("FAIL rst_data got %h exp 0", data_rx_o); end
    n_checks++; if (pending_event_o !== 1'b0) begin n_errors++; $display("FAIL rst_event got %0b exp 0", pending_event_o); end
    n_checks++; if (pending_cnt_o !== 14'd0) begin n_errors++; $display("FAIL rst_cnt got %0d exp 0", pending_cnt_o); end
    n_checks++; if (fifo_level_o !== 4'd0) begin n_errors++; $display("FAIL rst_level got %0d exp 0", fifo_level_o); end
    n_checks++; if (ovf_o !== 1'b0) begin n_errors++; $display("FAIL rst_ovf got %0b exp 0", ovf_o); end
    n_checks++; if (drop_cnt_o !== 8'd0) begin n_errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt_o); end
    n_checks++; if (data_rx_datasize_o !== 2'b10) begin n_errors++; $display("FAIL datasize got %b exp 10", data_rx_datasize_o); end
  endtask

  task automatic test_single();
    do_reset();
    data_rx_ready_i = 1'b1;
    set_ch(2, 28'h0ABCDEF);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_i);
      n_checks++; if (data_rx_valid_o !== 1'b0) begin n_errors++; $display("FAIL single_early_valid edge %0d got %0b exp 0", i, data_rx_valid_o); end
    end
    @(negedge clk_i);
    n_checks++; if (data_rx_valid_o !== 1'b1) begin n_errors++; $display("FAIL single_valid got %0b exp 1", data_rx_valid_o); end
    n_checks++; if (data_rx_o !== 32'h20ABCDEF) begin n_errors++; $display("FAIL single_word got %h exp 20abcdef", data_rx_o); end
    @(negedge clk_i);
    n_checks++; if (data_rx_valid_o !== 1'b0) begin n_errors++; $display("FAIL single_drained got %0b exp 0", data_rx_valid_o); end
    n_checks++; if (pending_cnt_o !== 14'd1) begin n_errors++; $display("FAIL single_cnt got %0d exp 1", pending_cnt_o); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp;
    do_reset();
    data_rx_ready_i = 1'b1;
    for (int c = 0; c < NB_CH; c++) set_ch(c, 28'(c + 1));
    run_count(20);
    n_checks++; if (got.size() != 4) begin n_errors++; $display("FAIL simul_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = (32'(i) << 28) | 32'(i + 1);
      if (i < got.size()) begin
        n_checks++; if (got[i] !== exp) begin n_errors++; $display("FAIL simul_word%0d got %h exp %h", i, got[i], exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NB_CH; c++) set_ch(c, 28'(r*16 + c + 1));
      repeat (10) @(negedge clk_i);
    end
    n_checks++; if (fifo_level_o !== 4'd8) begin n_errors++; $display("FAIL bp_level got %0d exp 8", fifo_level_o); end
    n_checks++; if (ovf_o !== 1'b0) begin n_errors++; $display("FAIL bp_ovf got %0b exp 0", ovf_o); end
    n_checks++; if (drop_cnt_o !== 8'd0) begin n_errors++; $display("FAIL bp_drop got %0d exp 0", drop_cnt_o); end
    n_checks++; if (data_rx_o !== 32'h00000001) begin n_errors++; $display("FAIL bp_head got %h exp 00000001", data_rx_o); end
    data_rx_ready_i = 1'b1;
    got.push_back(data_rx_o);
    @(negedge clk_i);
    n_checks++; if (fifo_level_o !== 4'd8) begin n_errors++; $display("FAIL bp_full_pushpop_level got %0d exp 8", fifo_level_o); end
    run_count(40);
    n_checks++; if (got.size() != 12) begin n_errors++; $display("FAIL bp_count got %0d exp 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      exp = (32'(i % 4) << 28) | 32'((i / 4) * 16 + (i % 4) + 1);
      if (i < got.size()) begin
        n_checks++; if (got[i] !== exp) begin n_errors++; $display("FAIL bp_word%0d got %h exp %h", i, got[i], exp); end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NB_CH; c++) set_ch(c, 28'(r*16 + c + 1));
      repeat (10) @(negedge clk_i);
    end
    n_checks++; if (fifo_level_o !== 4'd8) begin n_errors++; $display("FAIL ovf_level got %0d exp 8", fifo_level_o); end
    set_ch(0, 28'h0000111);
    repeat (10) @(negedge clk_i);
    n_checks++; if (drop_cnt_o !== 8'd0) begin n_errors++; $display("FAIL ovf_held_drop got %0d exp 0", drop_cnt_o); end
    set_ch(0, 28'h0000222);
    repeat (10) @(negedge clk_i);
    n_checks++; if (drop_cnt_o !== 8'd1) begin n_errors++; $display("FAIL ovf_drop got %0d exp 1", drop_cnt_o); end
    n_checks++; if (ovf_o !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %0b exp 1", ovf_o); end
    cfg_ovf_clr_i = 1'b1;
    @(negedge clk_i);
    cfg_ovf_clr_i = 1'b0;
    n_checks++; if (ovf_o !== 1'b0) begin n_errors++; $display("FAIL ovf_clr_flag got %0b exp 0", ovf_o); end
    n_checks++; if (drop_cnt_o !== 8'd0) begin n_errors++; $display("FAIL ovf_clr_drop got %0d exp 0", drop_cnt_o); end
    data_rx_ready_i = 1'b1;
    run_count(30);
    n_checks++; if (got.size() != 9) begin n_errors++; $display("FAIL ovf_drain_count got %0d exp 9", got.size()); end
    if (got.size() == 9) begin
      n_checks++; if (got[8] !== 32'h00000111) begin n_errors++; $display("FAIL ovf_kept_word got %h exp 00000111", got[8]); end
    end
  endtask

  task automatic test_threshold();
    bit ok;
    do_reset();
    cfg_evt_thr_i   = 14'd3;
    data_rx_ready_i = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      set_ch(0, 28'(n));
      wait_xfer(ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL thr_xfer%0d got none exp transfer", n); end
      @(negedge clk_i);
      n_checks++; if (pending_event_o !== ((n % 3) == 0)) begin n_errors++; $display("FAIL thr_event%0d got %0b exp %0b", n, pending_event_o, ((n % 3) == 0)); end
      n_checks++; if (pending_cnt_o !== 14'(n % 3)) begin n_errors++; $display("FAIL thr_cnt%0d got %0d exp %0d", n, pending_cnt_o, n % 3); end
      @(negedge clk_i);
      n_checks++; if (pending_event_o !== 1'b0) begin n_errors++; $display("FAIL thr_pulse_width%0d got %0b exp 0", n, pending_event_o); end
    end
    set_ch(0, 28'd8);
    wait_xfer(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL clr_xfer got none exp transfer"); end
    cfg_pending_clr_i = 1'b1;
    @(negedge clk_i);
    cfg_pending_clr_i = 1'b0;
    n_checks++; if (pending_cnt_o !== 14'd1) begin n_errors++; $display("FAIL clr_xfer_cnt got %0d exp 1", pending_cnt_o); end
    n_checks++; if (pending_event_o !== 1'b0) begin n_errors++; $display("FAIL clr_xfer_event got %0b exp 0", pending_event_o); end
    cfg_evt_thr_i = 14'd0;
    set_ch(0, 28'd9);
    wait_xfer(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL thr0_xfer got none exp transfer"); end
    @(negedge clk_i);
    n_checks++; if (pending_event_o !== 1'b1) begin n_errors++; $display("FAIL thr0_event got %0b exp 1", pending_event_o); end
    n_checks++; if (pending_cnt_o !== 14'd0) begin n_errors++; $display("FAIL thr0_cnt got %0d exp 0", pending_cnt_o); end
  endtask

  task automatic test_modes();
    do_reset();
    data_rx_ready_i = 1'b1;
    cfg_edge_mode_i = 4'b0010;
    set_ch(1, 28'h0000055);
    run_count(12);
    set_ch(1, 28'h0000056);
    run_count(12);
    n_checks++; if (got.size() != 1) begin n_errors++; $display("FAIL rise_count got %0d exp 1", got.size()); end
    if (got.size() == 1) begin
      n_checks++; if (got[0] !== 32'h10000055) begin n_errors++; $display("FAIL rise_word got %h exp 10000055", got[0]); end
    end
    got.delete();
    cfg_edge_mode_i = 4'b0000;
    cfg_ch_en_i     = 4'b1101;
    set_ch(1, 28'h0000066);
    run_count(12);
    n_checks++; if (got.size() != 0) begin n_errors++; $display("FAIL disabled_count got %0d exp 0", got.size()); end
    cfg_ch_en_i = 4'b1111;
    run_count(12);
    n_checks++; if (got.size() != 0) begin n_errors++; $display("FAIL reenable_static_count got %0d exp 0", got.size()); end
    set_ch(1, 28'h0000077);
    run_count(12);
    n_checks++; if (got.size() != 1) begin n_errors++; $display("FAIL reenable_event_count got %0d exp 1", got.size()); end
    if (got.size() == 1) begin
      n_checks++; if (got[0] !== 32'h10000077) begin n_errors++; $display("FAIL reenable_word got %h exp 10000077", got[0]); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_threshold();
    test_modes();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
